// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  // Controller phases: boot hold, normal running, memory-wait stall
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int PERF_CNT_W      = 32;
  localparam int DEF_BOOT_CYCLES = 2;
  localparam int DEF_MEM_TIMEOUT = 64;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for performance statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step up unless already all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: per-stage freeze/flush and PC source select.
// Priority in RUN/MEM_WAIT: memory wait > taken branch > data hazard.
// Optional statistics outputs are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = DEF_BOOT_CYCLES,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic hazard,
  input  logic branch_taken,
  input  logic mem_req,
  input  logic mem_ready,
  output logic if_freeze,
  output logic id_freeze,
  output logic exe_freeze,
  output logic mem_freeze,
  output logic if_flush,
  output logic id_flush,
  output logic pc_sel,
  output logic mem_timeout
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt,
  output logic [PERF_CNT_W-1:0] memwait_cnt
`endif
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic waitReq;
  logic waitExpired;
  logic waitActive;
  logic stallCycle;
  logic flushCycle;
  logic waitCycle;

  // The last counted wait cycle releases the freeze so the pipeline can move on
  assign waitReq     = mem_req && !mem_ready;
  assign waitExpired = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
  assign waitActive  = waitReq && !waitExpired;

  // Next-state logic for phase, boot/wait counters and the sticky timeout flag
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_W'(BOOT_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      RUN: begin
        if (waitReq) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!waitReq) begin
          state_d = RUN;
        end else if (waitExpired) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Stage controls decoded from the phase and this cycle's status inputs
  always_comb begin
    if_freeze  = 1'b0;
    id_freeze  = 1'b0;
    exe_freeze = 1'b0;
    mem_freeze = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    pc_sel     = 1'b0;
    stallCycle = 1'b0;
    flushCycle = 1'b0;
    waitCycle  = 1'b0;
    if (state_q == BOOT) begin
      if_freeze  = 1'b1;
      id_freeze  = 1'b1;
      exe_freeze = 1'b1;
      mem_freeze = 1'b1;
    end else if (waitActive) begin
      if_freeze  = 1'b1;
      id_freeze  = 1'b1;
      exe_freeze = 1'b1;
      mem_freeze = 1'b1;
      waitCycle  = 1'b1;
    end else if (branch_taken) begin
      if_flush   = 1'b1;
      id_flush   = 1'b1;
      pc_sel     = 1'b1;
      flushCycle = 1'b1;
    end else if (hazard) begin
      if_freeze  = 1'b1;
      id_freeze  = 1'b1;
      id_flush   = 1'b1;
      stallCycle = 1'b1;
    end
  end

  // Controller state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  sat_counter #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (stallCycle),
    .clear_i (1'b0),
    .count_o (stall_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (flushCycle),
    .clear_i (1'b0),
    .count_o (flush_cnt)
  );

  sat_counter #(.WIDTH(PERF_CNT_W)) u_memwait_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (waitCycle),
    .clear_i (1'b0),
    .count_o (memwait_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: two instances (memory timeout 8 and 4) share
// stimulus and are checked every cycle against a cycle-level behavioural model.
// Statistics outputs are checked too when PIPE_CTRL_PERF_CNT_EN is defined.
module tb_pipeline_ctrl;

  localparam int BOOT = 2;
  localparam int TO_A = 8;
  localparam int TO_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0;
  logic branch_taken = 1'b0;
  logic mem_req = 1'b0;
  logic mem_ready = 1'b0;

  logic ifFreeze [2];
  logic idFreeze [2];
  logic exeFreeze [2];
  logic memFreeze [2];
  logic ifFlush [2];
  logic idFlush [2];
  logic pcSel [2];
  logic memTimeout [2];
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stallCnt [2];
  logic [31:0] flushCnt [2];
  logic [31:0] memwaitCnt [2];
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state: boot cycles still to go, length of the current
  // run of consecutive memory-wait cycles, sticky timeout and statistics
  int          bootLeft [2];
  int          streak [2];
  bit          toSticky [2];
  int unsigned mStall [2];
  int unsigned mFlush [2];
  int unsigned mWait [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipeline_ctrl #(
      .BOOT_CYCLES (BOOT),
      .MEM_TIMEOUT ((g == 0) ? TO_A : TO_B)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .hazard       (hazard),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .if_freeze    (ifFreeze[g]),
      .id_freeze    (idFreeze[g]),
      .exe_freeze   (exeFreeze[g]),
      .mem_freeze   (memFreeze[g]),
      .if_flush     (ifFlush[g]),
      .id_flush     (idFlush[g]),
      .pc_sel       (pcSel[g]),
      .mem_timeout  (memTimeout[g])
`ifdef PIPE_CTRL_PERF_CNT_EN
      ,
      .stall_cnt    (stallCnt[g]),
      .flush_cnt    (flushCnt[g]),
      .memwait_cnt  (memwaitCnt[g])
`endif
    );
  end

  function automatic int timeoutOf(input int g);
    return (g == 0) ? TO_A : TO_B;
  endfunction

  function automatic logic [7:0] observed(input int g);
    return {ifFreeze[g], idFreeze[g], exeFreeze[g], memFreeze[g],
            ifFlush[g], idFlush[g], pcSel[g], memTimeout[g]};
  endfunction

  task automatic checkOutput(input string tag, input int g, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s dut%0d observed=%h expected=%h", tag, g, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int g = 0; g < 2; g++) begin
      bootLeft[g] = BOOT;
      streak[g]   = 0;
      toSticky[g] = 1'b0;
      mStall[g]   = 0;
      mFlush[g]   = 0;
      mWait[g]    = 0;
    end
  endtask

  // Called at a falling edge: assert reset, check the immediate boot-hold
  // outputs, then release at the next falling edge
  task automatic doReset();
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      checkOutput("reset_ctl", g, {24'd0, observed(g)}, 32'h0000_00F0);
    end
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  // Called at a falling edge: drive one cycle of inputs, check every output
  // against the model, advance the model, move to the next falling edge
  task automatic applyStimulus(input bit hz, input bit br, input bit req, input bit rdy);
    logic [7:0] e;
    bit         isWait;
    hazard       = hz;
    branch_taken = br;
    mem_req      = req;
    mem_ready    = rdy;
    #1;
    for (int g = 0; g < 2; g++) begin
      e      = 8'h00;
      isWait = 1'b0;
      if (bootLeft[g] > 0) begin
        e = 8'hF0;
      end else begin
        e[0]   = toSticky[g];
        isWait = req && !rdy && (streak[g] < timeoutOf(g));
        if (isWait) begin
          e[7:4] = 4'hF;
        end else if (br) begin
          e[3:1] = 3'b111;
        end else if (hz) begin
          e[7] = 1'b1;
          e[6] = 1'b1;
          e[2] = 1'b1;
        end
      end
      checkOutput("ctl", g, {24'd0, observed(g)}, {24'd0, e});
`ifdef PIPE_CTRL_PERF_CNT_EN
      checkOutput("stall_cnt", g, stallCnt[g], mStall[g]);
      checkOutput("flush_cnt", g, flushCnt[g], mFlush[g]);
      checkOutput("memwait_cnt", g, memwaitCnt[g], mWait[g]);
`endif
      if (bootLeft[g] > 0) begin
        bootLeft[g]--;
      end else begin
        if (req && !rdy) begin
          if (streak[g] == timeoutOf(g)) begin
            toSticky[g] = 1'b1;
            streak[g]   = 0;
          end else begin
            streak[g]++;
          end
        end else begin
          streak[g] = 0;
        end
        if (isWait) mWait[g]++;
        else if (br) mFlush[g]++;
        else if (hz) mStall[g]++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit reqState;
    modelReset();
    @(negedge clk);

    // Reset, boot hold then idle
    doReset();
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Three-cycle hazard stall, then branch overriding hazard
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Five-cycle memory wait with a branch presented mid-wait, then ready
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);

    // mem_req withdrawn mid-wait: no error, hazard handled normally
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);

    // Memory never answers: both instances time out, flag stays set
    repeat (11) applyStimulus(0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);

    // Reset in the middle of a wait clears the sticky flag
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    doReset();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);

    // Statistics scenario: 3 stalls, 1 branch, 5 wait cycles
    doReset();
    repeat (2) applyStimulus(0, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    repeat (5) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);

    // Randomised traffic with a slowly changing memory request
    reqState = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
      end
      if ($urandom_range(0, 99) < 20) reqState = ~reqState;
      applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
                    reqState, $urandom_range(0, 99) < 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage pipeline: generates per-stage freeze (hold) and flush (clear-to-bubble) controls for the IF, ID, EXE and MEM stage registers, plus the PC source select. It arbitrates between boot hold, memory-wait stalls, taken branches and data-hazard stalls with a fixed priority, and tracks multi-cycle memory waits with a timeout. It sits beside the pipeline, taking status from the ID/EXE/MEM stages and the memory controller, and driving every stage register's enable and clear inputs.

## Interface
- BOOT_CYCLES, 2: cycles the whole pipeline is held frozen after reset release (1..15).
- MEM_TIMEOUT, 64: maximum MEM_WAIT cycles before timeout error (2..1023).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hazard  in  1  data hazard detected in ID.
- branch_taken  in  1  EXE resolved a taken branch this cycle.
- mem_req  in  1  MEM stage holds a load/store needing the memory controller.
- mem_ready  in  1  memory controller completes the current access this cycle.
- if_freeze  out  1  hold PC and IF stage register.
- id_freeze  out  1  hold ID stage register.
- exe_freeze  out  1  hold EXE stage register.
- mem_freeze  out  1  hold MEM stage register.
- if_flush  out  1  clear IF stage register to zero (bubble).
- id_flush  out  1  clear ID stage register (bubble into EXE).
- pc_sel  out  1  1 = load PC from branch target, 0 = PC+4.
- mem_timeout  out  1  sticky error: memory wait exceeded MEM_TIMEOUT.

## Operation
- State (registered): BOOT, RUN, MEM_WAIT. Reset -> BOOT, boot counter = 0, wait counter = 0, mem_timeout = 0.
- BOOT: all four freezes = 1, flushes = 0, pc_sel = 0. Counter increments; at count BOOT_CYCLES-1 -> RUN.
- RUN / MEM_WAIT outputs are combinational from state and inputs, priority highest first:
  - Memory wait (mem_req=1, mem_ready=0): all freezes = 1, flushes = 0, pc_sel = 0. branch_taken and hazard ignored (EXE is held; branch re-presents next cycle).
  - Branch (branch_taken=1): if_flush = id_flush = 1, pc_sel = 1, all freezes = 0. Overrides hazard.
  - Hazard (hazard=1): if_freeze = id_freeze = 1, id_flush = 1, others 0.
  - Otherwise all outputs 0.
- RUN -> MEM_WAIT when mem_req=1 and mem_ready=0. Wait counter cleared on entry.
- MEM_WAIT: counter increments each cycle. mem_ready=1 -> RUN same edge (freeze deasserted in the ready cycle). Counter reaching MEM_TIMEOUT-1 with mem_ready still 0 -> set mem_timeout, force RUN (freezes drop; pipeline proceeds with whatever data is present).
- mem_req dropping to 0 while in MEM_WAIT -> RUN, no error.
- mem_timeout clears only on rst.
- Counters are unsigned, widths sized from parameters ($clog2), never wrap in normal flow.

## Timing
- All controls valid in the same cycle as their cause (zero-latency combinational from registered state).
- Branch flush lasts exactly the cycle branch_taken is high; one-cycle branch penalty of two bubbles.
- Hazard stall lasts while hazard=1; each cycle inserts one bubble into EXE.
- Reset asserted mid-wait or mid-branch: immediate BOOT, all freezes = 1, flushes = 0, pc_sel = 0, mem_timeout = 0.
- Output reset values: freezes 1 (BOOT), others 0.

## Configuration
- PIPE_CTRL_PERF_CNT_EN: when defined, adds outputs stall_cnt, flush_cnt, memwait_cnt (32-bit each, out): counting hazard-stall cycles, branch-flush cycles and memory-wait cycles in RUN/MEM_WAIT; saturate at 32'hFFFF_FFFF; reset to 0. When undefined, ports and logic are absent; control behaviour identical.

## Structure
- Package pipe_ctrl_pkg: state enum (BOOT, RUN, MEM_WAIT), counter width constant (32), default parameter values.
- Sub-module sat_counter (width parameter, inc, clear, saturating) instantiated three times under PIPE_CTRL_PERF_CNT_EN.

## Test plan
- Reset release, BOOT_CYCLES=2 -> all freezes 1 for exactly 2 cycles, then all outputs 0 with idle inputs.
- hazard=1 for 3 cycles -> if_freeze, id_freeze, id_flush = 1 for those 3 cycles; exe/mem_freeze = 0.
- hazard=1 and branch_taken=1 same cycle -> if_flush = id_flush = pc_sel = 1, if_freeze = 0.
- mem_req=1, mem_ready low 5 cycles then high -> all freezes 1 for 5 cycles, 0 in ready cycle; branch_taken during wait produces no flush.
- MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> mem_timeout sets after 4 wait cycles, state returns to RUN, stays set until rst.
- With PIPE_CTRL_PERF_CNT_EN: 3 hazard cycles + 1 branch + 5 memory-wait cycles -> stall_cnt=3, flush_cnt=1, memwait_cnt=5.
